// File: rtl/cylon_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : cylon_gen_if
//  Description : Control / pattern bundle for the cylon_gen LED pattern
//                generator.
//                  rate  - prescaler increment minus one (larger = faster)
//                  mode  - 0=CYLON1, 1=CYLON2, 2=WALK, 3=BLINK
//                  pause - freezes the prescaler and stops steps
//                  q     - registered LED pattern
//                  step  - one-cycle strobe on the first cycle of a new q
//                master : drives rate/mode/pause, observes q/step
//                slave  : the generator itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface cylon_gen_if #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 2
);
    logic [RATE_W-1:0] rate;
    logic [1:0]        mode;
    logic              pause;
    logic [WIDTH-1:0]  q;
    logic              step;

    modport master (
        output rate,
        output mode,
        output pause,
        input  q,
        input  step
    );

    modport slave (
        input  rate,
        input  mode,
        input  pause,
        output q,
        output step
    );
endinterface
`default_nettype wire

// File: rtl/cylon_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cylon_gen
//  Description : Parametrised LED pattern generator. A programmable prescaler
//                produces step ticks; each tick advances a position/direction
//                state (bounce, converging bounce, walk) or toggles a blink
//                phase. The state is decoded into a registered WIDTH-bit
//                pattern, and a strobe marks the first cycle of each new one.
//  Ports       : clock - system clock
//                reset - asynchronous active-high reset
//                bus   - cylon_gen_if.slave (rate, mode, pause in; q, step out)
//  Revision    : 1.0 - initial release
// ============================================================================
module cylon_gen #(
    parameter int WIDTH  = 8,
    parameter int MXPRE  = 21,
    parameter int RATE_W = 2
) (
    input  wire logic   clock,
    input  wire logic   reset,
    cylon_gen_if.slave  bus
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = MXPRE + 1;

    localparam logic [PW-1:0] c_POS_MAX = PW'(WIDTH - 1);
    localparam logic [PW-1:0] c_POS_ONE = PW'(1);

    localparam logic [1:0] c_MODE_CYLON1 = 2'd0;
    localparam logic [1:0] c_MODE_CYLON2 = 2'd1;
    localparam logic [1:0] c_MODE_WALK   = 2'd2;
    localparam logic [1:0] c_MODE_BLINK  = 2'd3;

    localparam logic c_DIR_UP = 1'b0;
    localparam logic c_DIR_DN = 1'b1;

    // State
    logic [MXPRE-1:0] r_pre;
    logic [PW-1:0]    r_pos;
    logic             r_dir;
    logic             r_phase;
    logic [1:0]       r_mode;
    logic             r_tick_d;
    logic [WIDTH-1:0] r_q;
    logic             r_step;

    // Next-state / decode
    logic [SW-1:0]    w_sum;
    logic             w_mode_chg;
    logic             w_tick;
    logic [MXPRE-1:0] w_pre_nxt;
    logic [PW-1:0]    w_pos_nxt;
    logic             w_dir_nxt;
    logic             w_phase_nxt;
    logic [WIDTH-1:0] w_eye;
    logic [WIDTH-1:0] w_mirror;
    logic [WIDTH-1:0] w_pattern;

    // Tick is the carry out of the prescaler accumulator.
    assign w_sum      = {1'b0, r_pre} + SW'(bus.rate) + SW'(1);
    assign w_mode_chg = (bus.mode != r_mode);
    // A mode change restarts everything and swallows any coincident tick.
    assign w_tick     = w_sum[MXPRE] & ~bus.pause & ~w_mode_chg;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre    <= '0;
            r_pos    <= '0;
            r_dir    <= c_DIR_UP;
            r_phase  <= 1'b0;
            r_mode   <= c_MODE_CYLON1;
            r_tick_d <= 1'b0;
            r_q      <= '0;
            r_step   <= 1'b0;
        end else begin
            r_pre    <= w_pre_nxt;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_phase  <= w_phase_nxt;
            r_mode   <= bus.mode;
            r_tick_d <= w_tick;
            r_q      <= w_pattern;
            // q lags state by one clock, so the strobe lags the tick by two.
            r_step   <= r_tick_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_pre_nxt   = r_pre;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_phase_nxt = r_phase;
        if (w_mode_chg) begin
            w_pre_nxt   = '0;
            w_pos_nxt   = '0;
            w_dir_nxt   = c_DIR_UP;
            w_phase_nxt = 1'b0;
        end else if (!bus.pause) begin
            w_pre_nxt = w_sum[MXPRE-1:0];
            if (w_tick) begin
                case (r_mode)
                    c_MODE_CYLON1, c_MODE_CYLON2: begin
                        if (r_dir == c_DIR_UP) begin
                            if (r_pos == c_POS_MAX) begin
                                w_dir_nxt = c_DIR_DN;
                                w_pos_nxt = c_POS_MAX - c_POS_ONE;
                            end else begin
                                w_pos_nxt = r_pos + c_POS_ONE;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_dir_nxt = c_DIR_UP;
                                w_pos_nxt = c_POS_ONE;
                            end else begin
                                w_pos_nxt = r_pos - c_POS_ONE;
                            end
                        end
                    end
                    c_MODE_WALK: begin
                        w_dir_nxt = c_DIR_UP;
                        w_pos_nxt = (r_pos == c_POS_MAX) ? '0 : (r_pos + c_POS_ONE);
                    end
                    default: begin
                        w_phase_nxt = ~r_phase;
                    end
                endcase
            end
        end
    end

    // --------------------------------------------------------------- decode
    assign w_eye    = WIDTH'(1) << r_pos;
    assign w_mirror = WIDTH'(1) << (c_POS_MAX - r_pos);

    always_comb begin
        w_pattern = w_eye;
        case (r_mode)
            c_MODE_CYLON2: w_pattern = w_eye | w_mirror;
            c_MODE_BLINK:  w_pattern = {WIDTH{r_phase}};
            default:       w_pattern = w_eye;
        endcase
    end

    assign bus.q    = r_q;
    assign bus.step = r_step;

endmodule
`default_nettype wire
